// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 8-bit RISC CPU: default widths, the opcode
// encoding and a decode helper used by controller, datapath and benches.
package cpu_defs;

    localparam int DWIDTH = 8;
    localparam int AWIDTH = 5;
    localparam int OPW    = 3;

    typedef enum logic [OPW-1:0] {
        OP_HLT = 3'b000,
        OP_SKZ = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_LDA = 3'b101,
        OP_STO = 3'b110,
        OP_JMP = 3'b111
    } opcode_t;

    // Opcodes whose ALU result depends on the memory operand.
    function automatic logic reads_operand(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: accumulator (a) combined with memory operand (b).
// Any opcode that is not an arithmetic/logic/load op passes a through.
module cpu_alu
    import cpu_defs::*;
#(
    parameter int DWIDTH = cpu_defs::DWIDTH,
    parameter int OPW    = cpu_defs::OPW
) (
    input  logic [OPW-1:0]    opcode,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] result
);

    always_comb begin
        result = a;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_LDA:  result = b;
            default: result = a;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Execution datapath of the 8-bit RISC CPU: PC, IR and accumulator driven by
// the controller strobes, plus the memory port and a sticky protocol-error flag.
module cpu_datapath
    import cpu_defs::*;
#(
    parameter int DWIDTH = cpu_defs::DWIDTH,
    parameter int AWIDTH = cpu_defs::AWIDTH,
    parameter int OPW    = cpu_defs::OPW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              sel,
    input  logic              rd,
    input  logic              wr,
    input  logic              ld_ir,
    input  logic              ld_ac,
    input  logic              data_e,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [OPW-1:0]    opcode,
    output logic              is_zero,
    output logic [AWIDTH-1:0] pc_q,
    output logic              bus_err
);

    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] ir;
    logic [DWIDTH-1:0] ac;
    logic [DWIDTH-1:0] alu_result;
    logic              bus_fault;

    assign opcode    = ir[DWIDTH-1 -: OPW];
    assign mem_addr  = sel ? pc : ir[AWIDTH-1:0];
    assign mem_wdata = data_e ? ac : '0;
    assign mem_we    = wr;
    assign mem_re    = rd;
    assign is_zero   = (ac == '0);
    assign pc_q      = pc;

    cpu_alu #(
        .DWIDTH (DWIDTH),
        .OPW    (OPW)
    ) u_alu (
        .opcode (opcode),
        .a      (ac),
        .b      (mem_rdata),
        .result (alu_result)
    );

    // Strobe combinations that can only come from a broken controller.
    always_comb begin
        bus_fault = (rd && wr)
                 || (wr && !data_e)
                 || (ld_ir && !rd)
                 || (ld_ac && !rd && reads_operand(opcode));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= '0;
            ir      <= '0;
            ac      <= '0;
            bus_err <= 1'b0;
        end else begin
            if (ld_pc) begin
                pc <= ir[AWIDTH-1:0];
            end else if (inc_pc) begin
                pc <= pc + AWIDTH'(1);
            end
            if (ld_ir) begin
                ir <= mem_rdata;
            end
            // ALU decode sees the old IR even when ld_ir fires in the same cycle.
            if (ld_ac) begin
                ac <= alu_result;
            end
            if (bus_fault) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: a table of per-cycle strobe vectors
// with expected pre-edge (combinational) and post-edge (registered) outputs.
module tb_cpu_datapath;
    import cpu_defs::*;

    typedef struct {
        logic       rst;
        logic       inc_pc;
        logic       ld_pc;
        logic       sel;
        logic       rd;
        logic       wr;
        logic       ld_ir;
        logic       ld_ac;
        logic       data_e;
        logic [7:0] rdata;
        logic [4:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [4:0] exp_pc;
        logic [2:0] exp_op;
        logic       exp_zero;
        logic       exp_err;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       inc_pc;
    logic       ld_pc;
    logic       sel;
    logic       rd;
    logic       wr;
    logic       ld_ir;
    logic       ld_ac;
    logic       data_e;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [2:0] opcode;
    logic       is_zero;
    logic [4:0] pc_q;
    logic       bus_err;

    int n_vectors = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    vec_t vecs[$];
    vec_t sb[$];

    cpu_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .sel       (sel),
        .rd        (rd),
        .wr        (wr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .data_e    (data_e),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .opcode    (opcode),
        .is_zero   (is_zero),
        .pc_q      (pc_q),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic inc, input logic ldpc, input logic s,
        input logic rdv, input logic wrv, input logic ldir, input logic ldac,
        input logic de, input logic [7:0] rdat,
        input logic [4:0] addr, input logic [7:0] wdat,
        input logic [4:0] pc, input logic [2:0] op, input logic z, input logic e);
        vec_t v;
        v.rst = r;       v.inc_pc = inc;   v.ld_pc = ldpc;  v.sel = s;
        v.rd = rdv;      v.wr = wrv;       v.ld_ir = ldir;  v.ld_ac = ldac;
        v.data_e = de;   v.rdata = rdat;   v.exp_addr = addr;
        v.exp_wdata = wdat; v.exp_pc = pc; v.exp_op = op;
        v.exp_zero = z;  v.exp_err = e;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        inc_pc    = v.inc_pc;
        ld_pc     = v.ld_pc;
        sel       = v.sel;
        rd        = v.rd;
        wr        = v.wr;
        ld_ir     = v.ld_ir;
        ld_ac     = v.ld_ac;
        data_e    = v.data_e;
        mem_rdata = v.rdata;
        sb.push_back(v);
        n_vectors++;
    endtask

    // Combinational outputs checked before the edge, registers just after it.
    task automatic checkOutput(input int idx);
        vec_t e;
        string tag;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1 (vec %0d)", idx);
            return;
        end
        e = sb.pop_front();
        tag = $sformatf("v%0d", idx);
        #1;
        if (e.rst) begin
            checkField({tag, ".mem_addr"},  8'(mem_addr), 8'(e.exp_addr));
            checkField({tag, ".mem_wdata"}, mem_wdata,    e.exp_wdata);
            checkField({tag, ".mem_we"},    8'(mem_we),   8'(e.wr));
            checkField({tag, ".mem_re"},    8'(mem_re),   8'(e.rd));
        end
        @(posedge clk);
        #1;
        checkField({tag, ".pc_q"},    8'(pc_q),    8'(e.exp_pc));
        checkField({tag, ".opcode"},  8'(opcode),  8'(e.exp_op));
        checkField({tag, ".is_zero"}, 8'(is_zero), 8'(e.exp_zero));
        checkField({tag, ".bus_err"}, 8'(bus_err), 8'(e.exp_err));
    endtask

    initial begin
        // rst inc ldpc sel rd wr ldir ldac de rdata | addr wdata | pc op z err
        vecs.push_back(mk(1,1,0,1,0,0,0,0,1,8'h00, 5'h00,8'h00, 5'h01,3'd0,1,0));
        vecs.push_back(mk(1,1,0,1,0,0,0,0,1,8'h00, 5'h01,8'h00, 5'h02,3'd0,1,0));
        vecs.push_back(mk(1,1,0,1,0,0,0,0,1,8'h00, 5'h02,8'h00, 5'h03,3'd0,1,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'hA7, 5'h03,8'h00, 5'h03,3'd5,1,0));
        vecs.push_back(mk(1,1,0,0,0,0,0,0,1,8'h00, 5'h07,8'h00, 5'h04,3'd5,1,0));
        vecs.push_back(mk(1,0,0,0,1,0,0,1,1,8'hF0, 5'h07,8'h00, 5'h04,3'd5,0,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'h4A, 5'h04,8'hF0, 5'h04,3'd2,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,0,1,1,8'h10, 5'h0A,8'hF0, 5'h04,3'd2,1,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'h93, 5'h04,8'h00, 5'h04,3'd4,1,0));
        vecs.push_back(mk(1,0,0,0,1,0,0,1,1,8'h5A, 5'h13,8'h00, 5'h04,3'd4,0,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'h7F, 5'h04,8'h5A, 5'h04,3'd3,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,0,1,1,8'h0F, 5'h1F,8'h5A, 5'h04,3'd3,0,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,1,1,8'hC5, 5'h04,8'h0A, 5'h04,3'd6,1,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'hA5, 5'h04,8'h00, 5'h04,3'd5,1,0));
        vecs.push_back(mk(1,0,0,0,1,0,0,1,1,8'h3C, 5'h05,8'h00, 5'h04,3'd5,0,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'hC5, 5'h04,8'h3C, 5'h04,3'd6,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0,0,1,8'h00, 5'h05,8'h3C, 5'h04,3'd6,0,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'hE9, 5'h04,8'h3C, 5'h04,3'd7,0,0));
        vecs.push_back(mk(1,1,1,1,0,0,0,0,1,8'h00, 5'h04,8'h3C, 5'h09,3'd7,0,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'hFF, 5'h09,8'h3C, 5'h09,3'd7,0,0));
        vecs.push_back(mk(1,0,1,1,0,0,0,0,1,8'h00, 5'h09,8'h3C, 5'h1F,3'd7,0,0));
        vecs.push_back(mk(1,1,0,1,0,0,0,0,1,8'h00, 5'h1F,8'h3C, 5'h00,3'd7,0,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,1,8'h00, 5'h00,8'h3C, 5'h00,3'd7,0,0));
        vecs.push_back(mk(1,0,0,1,1,1,0,0,1,8'h00, 5'h00,8'h3C, 5'h00,3'd7,0,1));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,1,8'h00, 5'h00,8'h3C, 5'h00,3'd7,0,1));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,1,8'h00, 5'h00,8'h3C, 5'h00,3'd0,1,0));
        vecs.push_back(mk(1,0,0,1,0,1,0,0,0,8'h00, 5'h00,8'h00, 5'h00,3'd0,1,1));
        vecs.push_back(mk(0,1,0,1,1,0,1,0,1,8'hFF, 5'h00,8'h00, 5'h00,3'd0,1,0));
        vecs.push_back(mk(1,0,0,1,0,0,1,0,1,8'h55, 5'h00,8'h00, 5'h00,3'd2,1,1));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,1,8'h00, 5'h00,8'h00, 5'h00,3'd0,1,0));
        vecs.push_back(mk(1,0,0,1,1,0,1,0,1,8'h41, 5'h00,8'h00, 5'h00,3'd2,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,1,1,8'h01, 5'h01,8'h00, 5'h00,3'd2,0,1));
        vecs.push_back(mk(0,0,0,1,0,0,0,0,1,8'h00, 5'h00,8'h01, 5'h00,3'd0,1,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,1,1,8'h77, 5'h00,8'h00, 5'h00,3'd0,1,0));
        vecs.push_back(mk(1,0,0,1,0,0,0,0,1,8'h00, 5'h00,8'h00, 5'h00,3'd0,1,0));

        // Reset held two cycles while the strobes toggle randomly.
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            {inc_pc, ld_pc, sel, rd, wr, ld_ir, ld_ac, data_e} = 8'($urandom);
            mem_rdata = 8'($urandom);
            @(posedge clk);
            #1;
        end
        n_vectors++;
        checkField("reset.pc_q",    8'(pc_q),    8'h00);
        checkField("reset.opcode",  8'(opcode),  8'h00);
        checkField("reset.is_zero", 8'(is_zero), 8'h01);
        checkField("reset.bus_err", 8'(bus_err), 8'h00);
        @(negedge clk);
        {inc_pc, ld_pc, rd, wr, ld_ir, ld_ac} = '0;
        sel    = 1'b1;
        data_e = 1'b1;
        #1;
        checkField("reset.mem_we",    8'(mem_we),   8'h00);
        checkField("reset.mem_re",    8'(mem_re),   8'h00);
        checkField("reset.mem_addr",  8'(mem_addr), 8'h00);
        checkField("reset.mem_wdata", mem_wdata,    8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i + 1);
        end

        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
        $finish;
    end

endmodule
